// File: rtl/parallel_in_serial_out_tx.sv
// parallel_in_serial_out_tx: serialises DATA_WIDTH-bit words received over a
// valid/ready handshake, one bit per enabled clock. A 1-deep holding register
// lets consecutive words stream with no idle bit between them. frame_start
// marks the first bit of every word so the downstream deserialiser can align.
module parallel_in_serial_out_tx #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  shift_en,
  output logic                  data_out,
  output logic                  bit_valid,
  output logic                  frame_start,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  data_out_q, data_out_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  frame_start_q, frame_start_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  accept_s;

  // The bit that goes on the line first for a given word image.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[DATA_WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the next bit to the head position of the shift register.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[DATA_WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[DATA_WIDTH-1:1]};
    end
  endfunction

  // in_ready comes straight from a flop, so accept has no path back into it.
  assign accept_s = in_valid && in_ready_q;

  // Next-state and output decode; every target starts from its held value.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    data_out_d    = data_out_q;
    frame_start_d = frame_start_q;

    case (state_q)
      ST_IDLE: begin
        // shift_en is irrelevant here; an accepted word starts immediately.
        if (accept_s) begin
          state_d       = ST_SHIFT;
          shreg_d       = data_in;
          data_out_d    = head_bit(data_in);
          bit_cnt_d     = '0;
          frame_start_d = 1'b1;
        end else begin
          data_out_d    = 1'b0;
          frame_start_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (shift_en && (bit_cnt_q == LAST_CNT)) begin
          // Word boundary: held word first, then bypass, else go idle.
          if (hold_full_q) begin
            shreg_d       = hold_q;
            data_out_d    = head_bit(hold_q);
            hold_full_d   = 1'b0;
            bit_cnt_d     = '0;
            frame_start_d = 1'b1;
          end else if (accept_s) begin
            shreg_d       = data_in;
            data_out_d    = head_bit(data_in);
            bit_cnt_d     = '0;
            frame_start_d = 1'b1;
          end else begin
            state_d       = ST_IDLE;
            data_out_d    = 1'b0;
            bit_cnt_d     = '0;
            frame_start_d = 1'b0;
          end
        end else begin
          if (shift_en) begin
            shreg_d       = advance(shreg_q);
            data_out_d    = head_bit(advance(shreg_q));
            bit_cnt_d     = bit_cnt_q + CNT_W'(1);
            frame_start_d = 1'b0;
          end else begin
            data_out_d    = data_out_q;
          end
          // accept implies the hold is empty, since in_ready = !hold_full.
          if (accept_s) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        bit_cnt_d     = '0;
        hold_full_d   = 1'b0;
        data_out_d    = 1'b0;
        frame_start_d = 1'b0;
      end
    endcase

    bit_valid_d = (state_d == ST_SHIFT);
    busy_d      = (state_d == ST_SHIFT) || hold_full_d;
    in_ready_d  = !hold_full_d;
  end

  // State, datapath and registered outputs; reset discards any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      data_out_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      data_out_q    <= data_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign data_out    = data_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_parallel_in_serial_out_tx.sv
// Directed testbench for parallel_in_serial_out_tx. Two instances share the
// stimulus: one MSB-first and one LSB-first; each test checks the relevant one.
module tb_parallel_in_serial_out_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       in_valid;
  logic       shift_en;

  logic m_ready, m_do, m_bv, m_fs, m_busy;
  logic l_ready, l_do, l_bv, l_fs, l_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] words [4];
  int         n_words;
  int         idx;

  always #5 clk = ~clk;

  parallel_in_serial_out_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(m_ready), .shift_en(shift_en), .data_out(m_do),
    .bit_valid(m_bv), .frame_start(m_fs), .busy(m_busy)
  );

  parallel_in_serial_out_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(l_ready), .shift_en(shift_en), .data_out(l_do),
    .bit_valid(l_bv), .frame_start(l_fs), .busy(l_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock while presenting words[] in order; advances on each accept.
  task automatic stream_tick();
    logic rdy;
    rdy = m_ready;
    tick();
    if (in_valid && rdy) begin
      idx++;
      if (idx < n_words) begin
        data_in = words[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int seq [11];

    reset    = 1'b1;
    in_valid = 1'b0;
    shift_en = 1'b1;
    data_in  = 8'h00;
    #12;
    check_eq("rst do",    {31'd0, m_do},    32'd0);
    check_eq("rst bv",    {31'd0, m_bv},    32'd0);
    check_eq("rst fs",    {31'd0, m_fs},    32'd0);
    check_eq("rst busy",  {31'd0, m_busy},  32'd0);
    check_eq("rst ready", {31'd0, m_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst ready lsb", {31'd0, l_ready}, 32'd1);

    // Test 1: MSB-first single word 8'hAD -> 1,0,1,0,1,1,0,1
    w = 8'hAD;
    data_in  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t1 do b%0d", i),   {31'd0, m_do},   {31'd0, w[7-i]});
      check_eq($sformatf("t1 fs b%0d", i),   {31'd0, m_fs},   {31'd0, (i == 0)});
      check_eq($sformatf("t1 bv b%0d", i),   {31'd0, m_bv},   32'd1);
      check_eq($sformatf("t1 busy b%0d", i), {31'd0, m_busy}, 32'd1);
      tick();
    end
    check_eq("t1 bv end",   {31'd0, m_bv},   32'd0);
    check_eq("t1 busy end", {31'd0, m_busy}, 32'd0);
    check_eq("t1 do end",   {31'd0, m_do},   32'd0);
    check_eq("t1 fs end",   {31'd0, m_fs},   32'd0);

    // Test 2: LSB-first 8'hB4 -> 0,0,1,0,1,1,0,1
    w = 8'hB4;
    data_in  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2 do b%0d", i), {31'd0, l_do}, {31'd0, w[i]});
      check_eq($sformatf("t2 fs b%0d", i), {31'd0, l_fs}, {31'd0, (i == 0)});
      tick();
    end
    check_eq("t2 bv end",   {31'd0, l_bv},   32'd0);
    check_eq("t2 busy end", {31'd0, l_busy}, 32'd0);

    // Test 3: back-to-back A5, 3C, FF with in_valid held high
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    n_words  = 3;
    idx      = 0;
    data_in  = words[0];
    in_valid = 1'b1;
    stream_tick();
    for (int b = 0; b < 24; b++) begin
      w = words[b / 8];
      check_eq($sformatf("t3 do b%0d", b), {31'd0, m_do}, {31'd0, w[7 - (b % 8)]});
      check_eq($sformatf("t3 fs b%0d", b), {31'd0, m_fs}, {31'd0, ((b % 8) == 0)});
      check_eq($sformatf("t3 bv b%0d", b), {31'd0, m_bv}, 32'd1);
      check_eq($sformatf("t3 rdy b%0d", b), {31'd0, m_ready},
               {31'd0, !(((b >= 1) && (b <= 7)) || ((b >= 9) && (b <= 15)))});
      stream_tick();
    end
    check_eq("t3 bv end",  {31'd0, m_bv},    32'd0);
    check_eq("t3 rdy end", {31'd0, m_ready}, 32'd1);

    // Test 4: stall 3 cycles after bit 3 of 8'hC3
    seq = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
    w = 8'hC3;
    words[0] = w;
    n_words  = 1;
    idx      = 0;
    data_in  = w;
    in_valid = 1'b1;
    stream_tick();
    for (int c = 0; c < 11; c++) begin
      check_eq($sformatf("t4 do c%0d", c), {31'd0, m_do}, {31'd0, w[7 - seq[c]]});
      check_eq($sformatf("t4 fs c%0d", c), {31'd0, m_fs}, {31'd0, (c == 0)});
      check_eq($sformatf("t4 bv c%0d", c), {31'd0, m_bv}, 32'd1);
      shift_en = ((c >= 3) && (c <= 5)) ? 1'b0 : 1'b1;
      tick();
    end
    shift_en = 1'b1;
    check_eq("t4 bv end", {31'd0, m_bv}, 32'd0);

    // Test 5: bypass 8'h81 presented exactly on the last-bit edge of 8'h7E
    data_in  = 8'h7E;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      w = (c < 8) ? 8'h7E : 8'h81;
      check_eq($sformatf("t5 do c%0d", c), {31'd0, m_do}, {31'd0, w[7 - (c % 8)]});
      check_eq($sformatf("t5 fs c%0d", c), {31'd0, m_fs}, {31'd0, ((c % 8) == 0)});
      check_eq($sformatf("t5 bv c%0d", c), {31'd0, m_bv}, 32'd1);
      if (c == 8) begin
        check_eq("t5 rdy after bypass", {31'd0, m_ready}, 32'd1);
      end
      if (c == 7) begin
        in_valid = 1'b1;
        data_in  = 8'h81;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check_eq("t5 bv end", {31'd0, m_bv}, 32'd0);

    // Test 6: async reset at bit 4 of 8'hF0 with 8'h0F held
    data_in  = 8'hF0;
    in_valid = 1'b1;
    tick();
    data_in  = 8'h0F;
    tick();
    in_valid = 1'b0;
    check_eq("t6 rdy held",  {31'd0, m_ready}, 32'd0);
    check_eq("t6 busy held", {31'd0, m_busy},  32'd1);
    tick();
    tick();
    tick();
    check_eq("t6 bv bit4", {31'd0, m_bv}, 32'd1);
    check_eq("t6 do bit4", {31'd0, m_do}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6 async do",    {31'd0, m_do},    32'd0);
    check_eq("t6 async bv",    {31'd0, m_bv},    32'd0);
    check_eq("t6 async fs",    {31'd0, m_fs},    32'd0);
    check_eq("t6 async busy",  {31'd0, m_busy},  32'd0);
    check_eq("t6 async ready", {31'd0, m_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    w = 8'h55;
    data_in  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t6 do b%0d", i), {31'd0, m_do}, {31'd0, w[7-i]});
      check_eq($sformatf("t6 fs b%0d", i), {31'd0, m_fs}, {31'd0, (i == 0)});
      check_eq($sformatf("t6 bv b%0d", i), {31'd0, m_bv}, 32'd1);
      tick();
    end
    check_eq("t6 bv end", {31'd0, m_bv}, 32'd0);
    tick();
    tick();
    check_eq("t6 no held word bv",   {31'd0, m_bv},   32'd0);
    check_eq("t6 no held word busy", {31'd0, m_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
